// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared definitions for the pipeline run/halt/step controller: FSM state
// encoding and default parameter values.
package pipeline_run_ctrl_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } run_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_STEP_W          = 8;
    localparam int DEF_PC_W            = 32;
    localparam int DEF_N_BKPT          = 2;

endpackage

// File: rtl/pipeline_run_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// press pulse on the accepted rising level (no pulse on release).
module btn_debounce
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_q;
    logic             level_qq;
    logic             press;

    // The two edge-detect stages place the pulse DEBOUNCE_CYCLES+3 cycles
    // after the raw edge is first sampled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            level    <= 1'b0;
            level_q  <= 1'b0;
            level_qq <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync1    <= i_btn;
            sync2    <= sync1;
            level_q  <= level;
            level_qq <= level_q;
            press    <= level_q & ~level_qq;
            if (sync2 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign o_press = press;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/halt/single-step controller for a pipeline clock enable, with PC
// breakpoints that halt before the matching instruction executes.
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP_W          = DEF_STEP_W,
    parameter int PC_W            = DEF_PC_W,
    parameter int N_BKPT          = DEF_N_BKPT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_btn_run,
    input  logic                   i_btn_step,
    input  logic [STEP_W-1:0]      i_step_count,
    input  logic [PC_W-1:0]        i_pc,
    input  logic [N_BKPT-1:0]      i_bkpt_en,
    input  logic [N_BKPT*PC_W-1:0] i_bkpt_pc,
    output logic                   o_clk_en,
    output logic                   o_halted,
    output logic [N_BKPT-1:0]      o_bkpt_hit,
    output logic [STEP_W-1:0]      o_steps_left,
    output run_state_e             o_dbg_state
);

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    run_state_e          state;
    logic [STEP_W-1:0]   steps_left;
    logic [N_BKPT-1:0]   bkpt_hit;
    logic                skip;
    logic                run_p;
    logic                step_p;
    logic [N_BKPT-1:0]   bkpt_vec;
    logic                bkpt_match;
    logic                clk_en;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_run),
        .o_press (run_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_step),
        .o_press (step_p)
    );

    // Skip masks all comparators for the first enabled cycle after resuming,
    // so a halt at a breakpoint PC does not immediately re-trigger.
    always_comb begin
        bkpt_vec = '0;
        for (int k = 0; k < N_BKPT; k++) begin
            bkpt_vec[k] = i_bkpt_en[k] && (i_pc == i_bkpt_pc[k*PC_W +: PC_W]) && !skip;
        end
    end

    assign bkpt_match = |bkpt_vec;
    assign clk_en     = ((state == RUN) || (state == STEP)) && !bkpt_match;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= HALTED;
            steps_left <= '0;
            bkpt_hit   <= '0;
            skip       <= 1'b0;
        end else begin
            if (clk_en) begin
                skip <= 1'b0;
            end
            case (state)
                HALTED: begin
                    if (run_p) begin
                        state    <= RUN;
                        skip     <= 1'b1;
                        bkpt_hit <= '0;
                    end else if (step_p) begin
                        state      <= STEP;
                        steps_left <= (i_step_count == '0) ? STEP_ONE : i_step_count;
                        skip       <= 1'b1;
                        bkpt_hit   <= '0;
                    end
                end
                RUN: begin
                    if (bkpt_match) begin
                        state      <= HALTED;
                        bkpt_hit   <= bkpt_hit | bkpt_vec;
                        steps_left <= '0;
                    end else if (run_p) begin
                        state <= HALTED;
                    end
                end
                STEP: begin
                    if (bkpt_match) begin
                        state      <= HALTED;
                        bkpt_hit   <= bkpt_hit | bkpt_vec;
                        steps_left <= '0;
                    end else if (run_p) begin
                        state      <= HALTED;
                        steps_left <= '0;
                    end else begin
                        steps_left <= steps_left - STEP_ONE;
                        if (steps_left == STEP_ONE) begin
                            state <= HALTED;
                        end
                    end
                end
                default: begin
                    state      <= HALTED;
                    steps_left <= '0;
                end
            endcase
        end
    end

    assign o_clk_en     = clk_en;
    assign o_halted     = (state == HALTED);
    assign o_bkpt_hit   = bkpt_hit;
    assign o_steps_left = steps_left;
    assign o_dbg_state  = state;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl with DEBOUNCE_CYCLES=4: a vector table
// of steady-state outcomes plus cycle-exact sequences for timing corners.
module tb_pipeline_run_ctrl;
    import pipeline_run_ctrl_pkg::*;

    localparam int DB = 4;

    logic        clk;
    logic        rst;
    logic        btn_run;
    logic        btn_step;
    logic [7:0]  step_count;
    logic [31:0] pc;
    logic [1:0]  bkpt_en;
    logic [63:0] bkpt_pc;
    logic        clk_en;
    logic        halted;
    logic [1:0]  bkpt_hit;
    logic [7:0]  steps_left;
    run_state_e  dbg_state;

    int checks = 0;
    int errors = 0;

    pipeline_run_ctrl #(
        .DEBOUNCE_CYCLES(DB), .STEP_W(8), .PC_W(32), .N_BKPT(2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_run    (btn_run),
        .i_btn_step   (btn_step),
        .i_step_count (step_count),
        .i_pc         (pc),
        .i_bkpt_en    (bkpt_en),
        .i_bkpt_pc    (bkpt_pc),
        .o_clk_en     (clk_en),
        .o_halted     (halted),
        .o_bkpt_hit   (bkpt_hit),
        .o_steps_left (steps_left),
        .o_dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        step;
        int          hold;
        logic [7:0]  cnt;
        logic [31:0] pc;
        logic [1:0]  en;
        logic        exp_clk_en;
        logic        exp_halted;
        logic [7:0]  exp_steps;
        logic [1:0]  exp_hit;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic press(input logic r, input logic s, input int hold);
        btn_run  = r;
        btn_step = s;
        repeat (hold) tick();
        btn_run  = 1'b0;
        btn_step = 1'b0;
    endtask

    initial begin
        int n_en;

        //            run   step  hold cnt    pc         en     clk  hlt  steps  hit
        vecs[0] = '{1'b1, 1'b0, 3, 8'd0, 32'h0,   2'b00, 1'b0, 1'b1, 8'd0, 2'b00}; // glitch
        vecs[1] = '{1'b1, 1'b0, 6, 8'd0, 32'h0,   2'b00, 1'b1, 1'b0, 8'd0, 2'b00}; // run
        vecs[2] = '{1'b0, 1'b1, 6, 8'd7, 32'h0,   2'b00, 1'b1, 1'b0, 8'd0, 2'b00}; // step ignored
        vecs[3] = '{1'b1, 1'b0, 6, 8'd0, 32'h0,   2'b00, 1'b0, 1'b1, 8'd0, 2'b00}; // halt
        vecs[4] = '{1'b0, 1'b1, 2, 8'd3, 32'h0,   2'b00, 1'b0, 1'b1, 8'd0, 2'b00}; // step glitch
        vecs[5] = '{1'b0, 1'b1, 6, 8'd3, 32'h0,   2'b00, 1'b0, 1'b1, 8'd0, 2'b00}; // burst done
        vecs[6] = '{1'b1, 1'b0, 6, 8'd0, 32'h100, 2'b01, 1'b0, 1'b1, 8'd0, 2'b01}; // skip then hit
        vecs[7] = '{1'b1, 1'b0, 6, 8'd0, 32'h100, 2'b00, 1'b1, 1'b0, 8'd0, 2'b00}; // hit cleared
        vecs[8] = '{1'b1, 1'b0, 6, 8'd0, 32'h100, 2'b00, 1'b0, 1'b1, 8'd0, 2'b00}; // halt

        rst        = 1'b1;
        btn_run    = 1'b0;
        btn_step   = 1'b0;
        step_count = 8'd0;
        pc         = 32'h0;
        bkpt_en    = 2'b00;
        bkpt_pc    = {32'h40, 32'h100};
        repeat (3) tick();
        chk("rst_clk_en", clk_en, 0);
        chk("rst_halted", halted, 1);
        chk("rst_hit", bkpt_hit, 0);
        chk("rst_steps", steps_left, 0);
        chk("rst_state", dbg_state, HALTED);
        rst = 1'b0;
        tick();

        // Run press: enable rises exactly 8 cycles after the first sampled high.
        btn_run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 10) btn_run = 1'b0;
            chk($sformatf("run_lat_k%0d", k), clk_en, (k >= 9) ? 1 : 0);
        end
        repeat (20) tick();
        chk("run_stays", clk_en, 1);
        press(1'b1, 1'b0, 10);
        chk("run_2nd_clk_en", clk_en, 0);
        chk("run_2nd_halted", halted, 1);
        repeat (20) tick();

        for (int i = 0; i < 9; i++) begin
            step_count = vecs[i].cnt;
            pc         = vecs[i].pc;
            bkpt_en    = vecs[i].en;
            press(vecs[i].run, vecs[i].step, vecs[i].hold);
            repeat (20) tick();
            chk($sformatf("vec%0d_clk_en", i), clk_en, vecs[i].exp_clk_en);
            chk($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halted);
            chk($sformatf("vec%0d_steps", i), steps_left, vecs[i].exp_steps);
            chk($sformatf("vec%0d_hit", i), bkpt_hit, vecs[i].exp_hit);
        end
        pc      = 32'h0;
        bkpt_en = 2'b00;

        // 5-step burst, cycle by cycle.
        step_count = 8'd5;
        btn_step   = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 6) btn_step = 1'b0;
            chk($sformatf("step5_en_k%0d", k), clk_en, (k >= 9 && k <= 13) ? 1 : 0);
            if (k >= 9 && k <= 13) chk($sformatf("step5_left_k%0d", k), steps_left, 5 - (k - 9));
        end
        chk("step5_end_steps", steps_left, 0);
        chk("step5_end_halted", halted, 1);
        repeat (20) tick();

        // Step count of zero behaves as one.
        step_count = 8'd0;
        press(1'b0, 1'b1, 6);
        n_en = 0;
        repeat (30) begin
            tick();
            if (clk_en) n_en++;
        end
        chk("step0_en_cycles", n_en, 1);
        chk("step0_halted", halted, 1);
        chk("step0_steps", steps_left, 0);

        // Breakpoint on entry 1 while running, then resume from that PC.
        bkpt_en = 2'b10;
        press(1'b1, 1'b0, 6);
        repeat (20) tick();
        chk("bkpt_running", clk_en, 1);
        pc = 32'h40;
        #1;
        chk("bkpt_same_cycle_en", clk_en, 0);
        tick();
        chk("bkpt_halted", halted, 1);
        chk("bkpt_hit", bkpt_hit, 2'b10);
        chk("bkpt_steps", steps_left, 0);
        repeat (20) tick();
        chk("bkpt_hit_held", bkpt_hit, 2'b10);
        btn_run = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 6) btn_run = 1'b0;
        end
        chk("resume_en", clk_en, 1);
        chk("resume_hit_clr", bkpt_hit, 0);
        chk("resume_halted", halted, 0);
        tick();
        pc = 32'h44;
        #1;
        repeat (5) tick();
        chk("resume_no_rehit_en", clk_en, 1);
        chk("resume_no_rehit_hit", bkpt_hit, 0);
        press(1'b1, 1'b0, 6);
        repeat (20) tick();
        chk("resume_halt", halted, 1);
        bkpt_en = 2'b00;
        pc      = 32'h0;

        // Simultaneous run and step: run wins.
        press(1'b1, 1'b1, 6);
        repeat (20) tick();
        chk("both_state", dbg_state, RUN);
        chk("both_clk_en", clk_en, 1);
        chk("both_steps", steps_left, 0);
        press(1'b1, 1'b0, 6);
        repeat (20) tick();
        chk("both_halt", halted, 1);

        // Reset in the middle of a 5-step burst.
        step_count = 8'd5;
        btn_step   = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 6) btn_step = 1'b0;
        end
        chk("burst_load", steps_left, 5);
        tick();
        tick();
        chk("burst_mid", steps_left, 3);
        rst = 1'b1;
        tick();
        chk("burst_rst_halted", halted, 1);
        chk("burst_rst_steps", steps_left, 0);
        chk("burst_rst_clk_en", clk_en, 0);
        rst = 1'b0;
        repeat (30) tick();
        chk("burst_post_halted", halted, 1);
        chk("burst_post_clk_en", clk_en, 0);

        // Reset mid-debounce leaves too short a press behind.
        btn_run = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        btn_run = 1'b0;
        repeat (20) tick();
        chk("db_rst_halted", halted, 1);
        chk("db_rst_clk_en", clk_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
